// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage data-memory access controller for the pipelined LC-3b core.
// Sequences LDR/LDB/STR/STB/LDI/STI handshakes, stalls the pipeline until the access
// completes, and hands formatted load data to the WB register.
//
// Optional feature: define MEM_STAGE_MISALIGN_TRAP_EN to trap word accesses at odd
// addresses (no request issued, mem_err set); otherwise address bit0 is silently cleared.
//
// Ports:
//   clk, reset                      core clock, synchronous active-high reset
//   mem_valid/is_load/is_store/
//   is_byte/is_ind                  decoded MEM-register controls
//   mem_address, mem_sr_data        effective address, store source data
//   dmem_address/read/write/
//   wmask/wdata                     registered data-memory request
//   dmem_rdata, dmem_resp           read data and one-cycle completion pulse
//   stall_mem                       combinational hold for IF..MEM registers
//   wb_ldata                        formatted load result
//   mem_err                         sticky timeout / misalign flag
module mem_stage_ctrl #(
    parameter int unsigned DMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_is_load,
    input  logic        mem_is_store,
    input  logic        mem_is_byte,
    input  logic        mem_is_ind,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_sr_data,
    output logic [15:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_wmask,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        stall_mem,
    output logic [15:0] wb_ldata,
    output logic        mem_err
);

    localparam int unsigned CNT_W = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(DMEM_TIMEOUT - 1);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IND  = 2'd1,
        S_ACC  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e           state_q;
    logic [15:0]      addr_q;      // access address; replaced by the pointer for indirect ops
    logic             is_load_q;
    logic             is_byte_q;
    logic [15:0]      sr_q;
    logic [CNT_W-1:0] wait_q;      // cycles the current request has waited without a response

    logic        mem_op;
    logic        req_active;
    logic        timeout_hit;
    logic        issue_now;
    logic [15:0] src_addr;
    logic        src_load;
    logic        src_byte;
    logic [15:0] src_sr;

    // Word accesses always address the even byte.
    function automatic logic [15:0] acc_addr(input logic [15:0] a, input logic byte_acc);
        return byte_acc ? a : {a[15:1], 1'b0};
    endfunction

    function automatic logic [1:0] acc_mask(input logic [15:0] a, input logic byte_acc);
        return byte_acc ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
    endfunction

    function automatic logic [15:0] acc_wdata(input logic [15:0] sr, input logic byte_acc);
        return byte_acc ? {sr[7:0], sr[7:0]} : sr;
    endfunction

    // Byte loads pick the addressed lane and sign-extend it.
    function automatic logic [15:0] load_fmt(input logic [15:0] rd, input logic hi,
                                             input logic byte_acc);
        logic [7:0] b;
        b = hi ? rd[15:8] : rd[7:0];
        return byte_acc ? {{8{b[7]}}, b} : rd;
    endfunction

    function automatic logic misaligned(input logic [15:0] a, input logic byte_acc);
        return TRAP_EN && !byte_acc && a[0];
    endfunction

    // Both load and store set is treated as a load.
    assign mem_op     = mem_valid & (mem_is_load | mem_is_store);
    assign req_active = dmem_read | dmem_write;
    assign stall_mem  = ((state_q == S_IDLE) && mem_op) || (state_q == S_IND) || (state_q == S_ACC);

    assign timeout_hit = (DMEM_TIMEOUT != 0) && req_active && !dmem_resp && (wait_q == WAIT_LAST);

    // Request source: live MEM-register inputs in IDLE, latched copy afterwards.
    assign src_addr = (state_q == S_IDLE) ? mem_address  : addr_q;
    assign src_load = (state_q == S_IDLE) ? mem_is_load  : is_load_q;
    assign src_byte = (state_q == S_IDLE) ? mem_is_byte  : is_byte_q;
    assign src_sr   = (state_q == S_IDLE) ? mem_sr_data  : sr_q;

    // Final access is issued straight from IDLE, or in the gap cycle after a pointer fetch.
    assign issue_now = ((state_q == S_IDLE) && mem_op && !mem_is_ind
                        && !misaligned(mem_address, mem_is_byte))
                     || ((state_q == S_ACC) && !req_active);

    // Access sequencer with registered request, load-data and error outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            is_load_q    <= 1'b0;
            is_byte_q    <= 1'b0;
            sr_q         <= '0;
            wait_q       <= '0;
            dmem_address <= '0;
            dmem_read    <= 1'b0;
            dmem_write   <= 1'b0;
            dmem_wmask   <= 2'b00;
            dmem_wdata   <= '0;
            wb_ldata     <= '0;
            mem_err      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mem_op) begin
                        addr_q    <= mem_address;
                        is_load_q <= mem_is_load;
                        is_byte_q <= mem_is_byte;
                        sr_q      <= mem_sr_data;
                        wait_q    <= '0;
                        if (mem_is_ind) begin
                            state_q      <= S_IND;
                            dmem_read    <= 1'b1;
                            dmem_address <= {mem_address[15:1], 1'b0};
                            dmem_wmask   <= 2'b11;
                        end else if (misaligned(mem_address, mem_is_byte)) begin
                            state_q <= S_DONE;
                            mem_err <= 1'b1;
                        end else begin
                            state_q <= S_ACC;
                        end
                    end
                end
                S_IND: begin
                    if (dmem_resp) begin
                        dmem_read <= 1'b0;
                        addr_q    <= dmem_rdata;
                        wait_q    <= '0;
                        if (misaligned(dmem_rdata, is_byte_q)) begin
                            state_q <= S_DONE;
                            mem_err <= 1'b1;
                        end else begin
                            state_q <= S_ACC;
                        end
                    end else if (timeout_hit) begin
                        dmem_read <= 1'b0;
                        mem_err   <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        wait_q <= wait_q + CNT_W'(1);
                    end
                end
                S_ACC: begin
                    // A response during the post-pointer gap cycle has no request to match.
                    if (req_active) begin
                        if (dmem_resp) begin
                            dmem_read  <= 1'b0;
                            dmem_write <= 1'b0;
                            state_q    <= S_DONE;
                            if (is_load_q) begin
                                wb_ldata <= load_fmt(dmem_rdata, addr_q[0], is_byte_q);
                            end
                        end else if (timeout_hit) begin
                            dmem_read  <= 1'b0;
                            dmem_write <= 1'b0;
                            mem_err    <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            wait_q <= wait_q + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (issue_now) begin
                dmem_read    <= src_load;
                dmem_write   <= !src_load;
                dmem_address <= acc_addr(src_addr, src_byte);
                dmem_wmask   <= acc_mask(src_addr, src_byte);
                dmem_wdata   <= acc_wdata(src_sr, src_byte);
                wait_q       <= '0;
            end
        end
    end

endmodule
